// File: rtl/seg_argmax_pkg.sv
// Shared constants and width helpers for the segmentation class-decision stage.
// Also used by the layer modules for fixed-point width derivation.
package seg_argmax_pkg;

  localparam int UNITS    = 4;
  localparam int IDX_BITW = 2;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fixed_bitw(input int int_bitw, input int frac_bitw);
    return int_bitw + frac_bitw;
  endfunction

endpackage

// File: rtl/seg_max2.sv
// Combinational signed 2-way max over {index, score} pairs.
// Ties keep the a-side, which callers wire as the lower class index.
module seg_max2
  import seg_argmax_pkg::*;
#(
  parameter int SCORE_BITW = 13
) (
  input  logic [IDX_BITW-1:0]   a_idx,
  input  logic [SCORE_BITW-1:0] a_score,
  input  logic [IDX_BITW-1:0]   b_idx,
  input  logic [SCORE_BITW-1:0] b_score,
  output logic [IDX_BITW-1:0]   win_idx,
  output logic [SCORE_BITW-1:0] win_score
);

  logic b_wins;

  assign b_wins    = $signed(b_score) > $signed(a_score);
  assign win_idx   = b_wins ? b_idx : a_idx;
  assign win_score = b_wins ? b_score : a_score;

endmodule

// File: rtl/seg_argmax.sv
// Per-pixel argmax over four class scores with a two-stage compare tree,
// plus a per-frame class histogram published at the end of each window.
module seg_argmax
  import seg_argmax_pkg::*;
#(
  parameter int HEIGHT    = 480,
  parameter int WIDTH     = 640,
  parameter int W_HEIGHT  = 525,
  parameter int W_WIDTH   = 800,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  localparam int FIXED_BITW = fixed_bitw(INT_BITW, FRAC_BITW),
  localparam int V_BITW     = log2_ceil(W_HEIGHT),
  localparam int H_BITW     = log2_ceil(W_WIDTH),
  localparam int CNT_BITW   = log2_ceil(HEIGHT * WIDTH + 1)
) (
  input  logic                           clock,
  input  logic                           n_rst,
  input  logic [0:FIXED_BITW*UNITS-1]    in_y,
  input  logic [V_BITW-1:0]              in_vcnt,
  input  logic [H_BITW-1:0]              in_hcnt,
  output logic [IDX_BITW-1:0]            out_label,
  output logic [FIXED_BITW-1:0]          out_score,
  output logic [V_BITW-1:0]              out_vcnt,
  output logic [H_BITW-1:0]              out_hcnt,
  output logic [0:CNT_BITW*UNITS-1]      out_hist,
  output logic                           out_hist_valid
);

  logic [FIXED_BITW-1:0] score [UNITS];

  for (genvar k = 0; k < UNITS; k++) begin : g_unpack
    assign score[k] = in_y[FIXED_BITW*k +: FIXED_BITW];
  end

  logic [IDX_BITW-1:0]   p_lo_idx, p_hi_idx, s2_idx;
  logic [FIXED_BITW-1:0] p_lo_score, p_hi_score, s2_score;

  seg_max2 #(.SCORE_BITW(FIXED_BITW)) u_max_lo (
    .a_idx(2'd0), .a_score(score[0]),
    .b_idx(2'd1), .b_score(score[1]),
    .win_idx(p_lo_idx), .win_score(p_lo_score)
  );

  seg_max2 #(.SCORE_BITW(FIXED_BITW)) u_max_hi (
    .a_idx(2'd2), .a_score(score[2]),
    .b_idx(2'd3), .b_score(score[3]),
    .win_idx(p_hi_idx), .win_score(p_hi_score)
  );

  logic [IDX_BITW-1:0]   s1_lo_idx, s1_hi_idx;
  logic [FIXED_BITW-1:0] s1_lo_score, s1_hi_score;
  logic [V_BITW-1:0]     s1_vcnt;
  logic [H_BITW-1:0]     s1_hcnt;
  logic                  s1_vld, s2_vld;

  seg_max2 #(.SCORE_BITW(FIXED_BITW)) u_max_fin (
    .a_idx(s1_lo_idx), .a_score(s1_lo_score),
    .b_idx(s1_hi_idx), .b_score(s1_hi_score),
    .win_idx(s2_idx), .win_score(s2_score)
  );

  // s1_vld/s2_vld keep the all-zero reset contents of the pipe from
  // looking like a real (0,0) pixel to the sync logic.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      s1_lo_idx   <= '0;
      s1_lo_score <= '0;
      s1_hi_idx   <= '0;
      s1_hi_score <= '0;
      s1_vcnt     <= '0;
      s1_hcnt     <= '0;
      s1_vld      <= 1'b0;
      out_label   <= '0;
      out_score   <= '0;
      out_vcnt    <= '0;
      out_hcnt    <= '0;
      s2_vld      <= 1'b0;
    end else begin
      s1_lo_idx   <= p_lo_idx;
      s1_lo_score <= p_lo_score;
      s1_hi_idx   <= p_hi_idx;
      s1_hi_score <= p_hi_score;
      s1_vcnt     <= in_vcnt;
      s1_hcnt     <= in_hcnt;
      s1_vld      <= 1'b1;
      out_label   <= s2_idx;
      out_score   <= s2_score;
      out_vcnt    <= s1_vcnt;
      out_hcnt    <= s1_hcnt;
      s2_vld      <= s1_vld;
    end
  end

  logic                sync;
  logic                at_origin, synced, active, count_en, frame_end;
  logic [CNT_BITW-1:0] acc      [UNITS];
  logic [CNT_BITW-1:0] acc_next [UNITS];

  assign at_origin = s2_vld && (out_vcnt == '0) && (out_hcnt == '0);
  assign synced    = sync || at_origin;
  assign active    = s2_vld && (int'(out_vcnt) < HEIGHT) && (int'(out_hcnt) < WIDTH);
  assign count_en  = synced && active;
  assign frame_end = synced && s2_vld
                     && (out_vcnt == V_BITW'(W_HEIGHT - 1))
                     && (out_hcnt == H_BITW'(W_WIDTH - 1));

  always_comb begin
    for (int k = 0; k < UNITS; k++) begin
      acc_next[k] = acc[k];
      if (count_en && (out_label == IDX_BITW'(k))) acc_next[k] = acc[k] + CNT_BITW'(1);
    end
  end

  // The frame-end pixel's own contribution is published and the counters
  // restart from zero on the same edge.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      sync           <= 1'b0;
      out_hist       <= '0;
      out_hist_valid <= 1'b0;
      for (int k = 0; k < UNITS; k++) acc[k] <= '0;
    end else begin
      sync           <= synced;
      out_hist_valid <= frame_end;
      if (frame_end) begin
        for (int k = 0; k < UNITS; k++) begin
          out_hist[CNT_BITW*k +: CNT_BITW] <= acc_next[k];
          acc[k] <= '0;
        end
      end else begin
        for (int k = 0; k < UNITS; k++) acc[k] <= acc_next[k];
      end
    end
  end

endmodule

// File: tb/tb_seg_argmax.sv
// Directed bench for seg_argmax: argmax/tie cases, a random back-to-back
// stream against a reference argmax, histogram frames and reset behaviour.
module tb_seg_argmax;

  localparam int HEIGHT = 2, WIDTH = 4, W_HEIGHT = 3, W_WIDTH = 6;
  localparam int FB = 13, VB = 2, HB = 3, CB = 4;
  localparam int NPIX = W_HEIGHT * W_WIDTH;

  logic              clock = 1'b0;
  logic              n_rst;
  logic [0:FB*4-1]   in_y;
  logic [VB-1:0]     in_vcnt;
  logic [HB-1:0]     in_hcnt;
  logic [1:0]        out_label;
  logic [FB-1:0]     out_score;
  logic [VB-1:0]     out_vcnt;
  logic [HB-1:0]     out_hcnt;
  logic [0:CB*4-1]   out_hist;
  logic              out_hist_valid;

  seg_argmax #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH),
    .INT_BITW(5), .FRAC_BITW(8)
  ) dut (
    .clock(clock), .n_rst(n_rst), .in_y(in_y), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_label(out_label), .out_score(out_score), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .out_hist(out_hist), .out_hist_valid(out_hist_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int g_tick, pulses, pulse_tick;
  logic [CB*4-1:0] hist_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [FB-1:0] u0, u1, u2, u3, input int v, input int h);
    in_y    = {u0, u1, u2, u3};
    in_vcnt = VB'(v);
    in_hcnt = HB'(h);
  endtask

  function automatic int cls(input int pat, input int v, input int h);
    int idx;
    if (v >= HEIGHT || h >= WIDTH) return (pat == 1) ? 3 : 0;
    if (pat == 2) return 1;
    idx = v * WIDTH + h;
    case (idx)
      0, 1, 2: return 0;
      3, 4:    return 1;
      5:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic run_px(input int start, input int n, input int pat);
    logic [FB-1:0] u [4];
    int p, v, h, c;
    for (int j = 0; j < n; j++) begin
      p = (start + j) % NPIX;
      v = p / W_WIDTH;
      h = p % W_WIDTH;
      c = cls(pat, v, h);
      for (int k = 0; k < 4; k++) u[k] = (k == c) ? 13'h0100 : 13'h1F00;
      drive(u[0], u[1], u[2], u[3], v, h);
      tick();
      g_tick++;
      if (out_hist_valid) begin
        pulses++;
        pulse_tick = g_tick;
        hist_cap   = out_hist;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_label"}, 64'(out_label), 0);
    chk({tag, "_score"}, 64'(out_score), 0);
    chk({tag, "_vcnt"},  64'(out_vcnt), 0);
    chk({tag, "_hcnt"},  64'(out_hcnt), 0);
    chk({tag, "_hist"},  64'(out_hist), 0);
    chk({tag, "_valid"}, 64'(out_hist_valid), 0);
  endtask

  logic [FB-1:0] pool [8];
  logic [FB-1:0] ru [4];
  int exp_lab [100];
  int exp_sc  [100];
  int exp_v   [100];
  int exp_h   [100];

  initial begin
    int best;
    n_rst = 1'b0;
    drive(13'h0, 13'h0, 13'h0, 13'h0, 0, 0);
    tick();
    tick();
    chk_zero("rst");
    n_rst = 1'b1;

    drive(13'h0100, 13'h1E00, 13'h0380, 13'h0040, 1, 2);
    tick();
    tick();
    chk("a_label", 64'(out_label), 2);
    chk("a_score", 64'(out_score), 13'h0380);
    chk("a_vcnt",  64'(out_vcnt), 1);
    chk("a_hcnt",  64'(out_hcnt), 2);

    drive(13'h0000, 13'h0000, 13'h0000, 13'h0000, 2, 5);
    tick(); tick();
    chk("zero_label", 64'(out_label), 0);
    chk("zero_score", 64'(out_score), 0);
    drive(13'h0080, 13'h0080, 13'h0080, 13'h0080, 2, 3);
    tick(); tick();
    chk("eq_label", 64'(out_label), 0);
    chk("eq_score", 64'(out_score), 13'h0080);
    drive(13'h1F00, 13'h1F80, 13'h1E00, 13'h1D00, 1, 4);
    tick(); tick();
    chk("neg_label", 64'(out_label), 1);
    chk("neg_score", 64'(out_score), 13'h1F80);
    drive(13'h0010, 13'h0000, 13'h0010, 13'h0000, 2, 1);
    tick(); tick();
    chk("pairtie_label", 64'(out_label), 0);
    drive(13'h0000, 13'h0010, 13'h0000, 13'h0020, 2, 1);
    tick(); tick();
    chk("hi_label", 64'(out_label), 3);
    chk("hi_score", 64'(out_score), 13'h0020);

    pool[0] = 13'h0000; pool[1] = 13'h0100; pool[2] = 13'h1F00; pool[3] = 13'h0FFF;
    pool[4] = 13'h1000; pool[5] = 13'h0080; pool[6] = 13'h1FFF; pool[7] = 13'h0001;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        for (int k = 0; k < 4; k++) ru[k] = pool[$urandom_range(0, 7)];
        best = 0;
        for (int k = 1; k < 4; k++) if ($signed(ru[k]) > $signed(ru[best])) best = k;
        exp_lab[i] = best;
        exp_sc[i]  = int'(ru[best]);
        exp_v[i]   = $urandom_range(0, W_HEIGHT - 1);
        exp_h[i]   = $urandom_range(0, W_WIDTH - 1);
        drive(ru[0], ru[1], ru[2], ru[3], exp_v[i], exp_h[i]);
      end
      tick();
      if (i >= 1) begin
        chk("rnd_label", 64'(out_label), 64'(exp_lab[i-1]));
        chk("rnd_score", 64'(out_score), 64'(exp_sc[i-1]));
        chk("rnd_vcnt",  64'(out_vcnt),  64'(exp_v[i-1]));
        chk("rnd_hcnt",  64'(out_hcnt),  64'(exp_h[i-1]));
      end
    end

    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    g_tick = 0; pulses = 0; pulse_tick = -1; hist_cap = '0;
    run_px(0, NPIX, 1);
    run_px(0, 3, 2);
    chk("f1_pulses", 64'(pulses), 1);
    chk("f1_tick",   64'(pulse_tick), NPIX + 2);
    chk("f1_hist",   64'(hist_cap), {4'd3, 4'd2, 4'd1, 4'd2});
    run_px(3, NPIX - 3, 2);
    run_px(0, 3, 1);
    chk("f2_pulses", 64'(pulses), 2);
    chk("f2_tick",   64'(pulse_tick), 2 * NPIX + 2);
    chk("f2_hist",   64'(hist_cap), {4'd0, 4'd8, 4'd0, 4'd0});
    chk("f2_hold",   64'(out_hist), {4'd0, 4'd8, 4'd0, 4'd0});

    #2 n_rst = 1'b0;
    #1 chk_zero("async");
    tick();
    n_rst = 1'b1;

    g_tick = 0; pulses = 0; pulse_tick = -1; hist_cap = '0;
    run_px(W_WIDTH + 2, NPIX - (W_WIDTH + 2), 1);
    chk("mid_nopulse", 64'(pulses), 0);
    run_px(0, NPIX, 1);
    run_px(0, 3, 1);
    chk("mid_pulses", 64'(pulses), 1);
    chk("mid_tick",   64'(pulse_tick), 2 * NPIX - (W_WIDTH + 2) + 2);
    chk("mid_hist",   64'(hist_cap), {4'd3, 4'd2, 4'd1, 4'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
